fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage: PC, branch redirect, IF/ID register, halt detect
module fetch_stage #(
    parameter int          N         = 64,
    parameter int          IMEM_AW   = 7,
    parameter logic [31:0] HALT_WORD = 32'hb400001f,
    parameter logic [31:0] NOP_WORD  = 32'h8b1f03ff
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_F,
    input  logic               flush_D,
    input  logic               pcsrc,
    input  logic [N-1:0]       pc_branch,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [N-1:0]       pc_F,
    output logic [31:0]        instr_D,
    output logic [N-1:0]       pc_D,
    output logic               valid_D,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] pcd_q, pcd_d;
    logic         valid_q, valid_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         load;
    logic         hit_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            pcd_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcd_d    = pcd_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        hit_halt = 1'b0;

        // IF/ID register: a redirect squashes the wrong-path word just like flush_D
        if (flush_D || pcsrc) begin
            instr_d = NOP_WORD;
            pcd_d   = '0;
            valid_d = 1'b0;
        end else if (stall_F) begin
            instr_d = instr_q;
        end else if (state_q == HALTED) begin
            instr_d = NOP_WORD;
            pcd_d   = '0;
            valid_d = 1'b0;
        end else begin
            load     = 1'b1;
            hit_halt = (imem_q == HALT_WORD);
            instr_d  = imem_q;
            pcd_d    = pc_q;
            valid_d  = 1'b1;
        end

        // PC stays on the halt word's address so a later redirect is the only way out
        if (pcsrc) begin
            pc_d = pc_branch;
        end else if (stall_F || state_q == HALTED || hit_halt) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + N'(4);
        end

        if (pcsrc) begin
            state_d = RUN;
        end else if (hit_halt) begin
            state_d = HALTED;
        end

        if (load && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign pc_F        = pc_q;
    assign instr_D     = instr_q;
    assign pc_D        = pcd_q;
    assign valid_D     = valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage with a behavioural ROM
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hb400001f;
    localparam logic [31:0] NOP  = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset, stall_F, flush_D, pcsrc;
    logic [63:0] pc_branch;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F, pc_D;
    logic [31:0] instr_D, fetch_count;
    logic        valid_D, halted;

    logic [31:0] rom [0:127];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign imem_q = rom[imem_addr];

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_F     (stall_F),
        .flush_D     (flush_D),
        .pcsrc       (pcsrc),
        .pc_branch   (pc_branch),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .pc_F        (pc_F),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .valid_D     (valid_D),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] ins, input logic [63:0] pcd,
                          input logic vld);
        chk({tag, ".instr_D"}, 64'(instr_D), 64'(ins));
        chk({tag, ".pc_D"}, pc_D, pcd);
        chk({tag, ".valid_D"}, 64'(valid_D), 64'(vld));
    endtask

    task automatic chk_st(input string tag, input logic [63:0] pc, input logic hlt,
                          input logic [31:0] cnt);
        chk({tag, ".pc_F"}, pc_F, pc);
        chk({tag, ".halted"}, 64'(halted), 64'(hlt));
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(cnt));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'h9100_0000 + 32'(i);
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = NOP;
        rom[3]  = NOP;
        rom[15] = HALT;

        reset = 1'b1; stall_F = 1'b0; flush_D = 1'b0; pcsrc = 1'b0; pc_branch = '0;
        tick();
        tick();
        chk_if("rst", NOP, 64'h0, 1'b0);
        chk_st("rst", 64'h0, 1'b0, 32'd0);
        reset = 1'b0;

        // free run through words 0..3
        chk("run0.imem_addr", 64'(imem_addr), 64'd0);
        tick();
        chk("run1.imem_addr", 64'(imem_addr), 64'd1);
        chk_if("run1", 32'hf8000001, 64'h0, 1'b1);
        tick();
        chk("run2.imem_addr", 64'(imem_addr), 64'd2);
        chk_if("run2", 32'hf8008002, 64'h4, 1'b1);
        tick();
        chk("run3.imem_addr", 64'(imem_addr), 64'd3);
        chk_if("run3", NOP, 64'h8, 1'b1);
        chk_st("run3", 64'hC, 1'b0, 32'd3);
        tick();
        tick();
        chk_if("run5", rom[4], 64'h10, 1'b1);
        chk_st("run5", 64'h14, 1'b0, 32'd5);

        // two-cycle stall at 0x14
        stall_F = 1'b1;
        tick();
        tick();
        chk_if("stall", rom[4], 64'h10, 1'b1);
        chk_st("stall", 64'h14, 1'b0, 32'd5);
        stall_F = 1'b0;
        tick();
        chk_if("unstall", rom[5], 64'h14, 1'b1);
        chk_st("unstall", 64'h18, 1'b0, 32'd6);

        // redirect beats stall
        pcsrc = 1'b1; pc_branch = 64'h40; stall_F = 1'b1;
        tick();
        chk_if("br40", NOP, 64'h0, 1'b0);
        chk_st("br40", 64'h40, 1'b0, 32'd6);
        pcsrc = 1'b0; stall_F = 1'b0;
        tick();
        chk_if("br40n", rom[16], 64'h40, 1'b1);
        chk_st("br40n", 64'h44, 1'b0, 32'd7);

        // walk into the halt word, with a stall while it sits on imem_q
        pcsrc = 1'b1; pc_branch = 64'h34;
        tick();
        pcsrc = 1'b0;
        tick();
        tick();
        chk_if("pre_halt", rom[14], 64'h38, 1'b1);
        chk_st("pre_halt", 64'h3C, 1'b0, 32'd9);
        stall_F = 1'b1;
        tick();
        chk_st("halt_stall", 64'h3C, 1'b0, 32'd9);
        stall_F = 1'b0;
        tick();
        chk_if("halt", HALT, 64'h3C, 1'b1);
        chk_st("halt", 64'h3C, 1'b1, 32'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_if($sformatf("halted%0d", i), NOP, 64'h0, 1'b0);
            chk_st($sformatf("halted%0d", i), 64'h3C, 1'b1, 32'd10);
        end

        // redirect out of HALTED
        pcsrc = 1'b1; pc_branch = 64'h20;
        tick();
        chk_if("unhalt", NOP, 64'h0, 1'b0);
        chk_st("unhalt", 64'h20, 1'b0, 32'd10);
        pcsrc = 1'b0;
        tick();
        chk_if("unhalt_n", rom[8], 64'h20, 1'b1);
        chk_st("unhalt_n", 64'h24, 1'b0, 32'd11);
        tick();
        tick();
        tick();
        chk_st("pre_rst", 64'h30, 1'b0, 32'd14);

        // reset wins over flush mid-run
        reset = 1'b1; flush_D = 1'b1;
        tick();
        chk_if("midrst", NOP, 64'h0, 1'b0);
        chk_st("midrst", 64'h0, 1'b0, 32'd0);
        reset = 1'b0; flush_D = 1'b0;

        // aliasing above the ROM and misaligned target
        pcsrc = 1'b1; pc_branch = 64'h200;
        tick();
        chk("alias.pc_F", pc_F, 64'h200);
        chk("alias.imem_addr", 64'(imem_addr), 64'd0);
        pc_branch = 64'h4A;
        tick();
        chk("mis.imem_addr", 64'(imem_addr), 64'd18);
        pcsrc = 1'b0;
        tick();
        chk_if("mis", rom[18], 64'h4A, 1'b1);
        chk_st("mis", 64'h4E, 1'b0, 32'd1);

        // flush alone bubbles IF/ID but lets PC advance
        flush_D = 1'b1;
        tick();
        chk_if("flush", NOP, 64'h0, 1'b0);
        chk_st("flush", 64'h52, 1'b0, 32'd1);
        flush_D = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
